// File: rtl/sram_parity_ctrl_pkg.sv
// Shared types and helpers for the byte-parity protected SRAM controller:
// FSM state encoding, lane geometry and the per-byte even-parity function.
package sram_parity_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CHK,
    RSP
  } state_t;

  localparam int LANES     = 4;
  localparam int LANE_W    = 8;
  localparam int LANE_BITS = LANE_W + 1;
  localparam int DATA_W    = LANES * LANE_W;
  localparam int WORD_W    = LANES * LANE_BITS;

  function automatic logic [LANES-1:0] byte_parity(input logic [DATA_W-1:0] data);
    logic [LANES-1:0] par;
    for (int i = 0; i < LANES; i++) par[i] = ^data[i*LANE_W +: LANE_W];
    return par;
  endfunction

  // Each stored lane is {parity, data byte}; lane i occupies bits [9i+8:9i].
  function automatic logic [WORD_W-1:0] pack_word(input logic [DATA_W-1:0] data,
                                                  input logic [LANES-1:0]  par);
    logic [WORD_W-1:0] word;
    for (int i = 0; i < LANES; i++)
      word[i*LANE_BITS +: LANE_BITS] = {par[i], data[i*LANE_W +: LANE_W]};
    return word;
  endfunction

  function automatic logic [DATA_W-1:0] word_data(input logic [WORD_W-1:0] word);
    logic [DATA_W-1:0] data;
    for (int i = 0; i < LANES; i++) data[i*LANE_W +: LANE_W] = word[i*LANE_BITS +: LANE_W];
    return data;
  endfunction

  function automatic logic [LANES-1:0] word_parity(input logic [WORD_W-1:0] word);
    logic [LANES-1:0] par;
    for (int i = 0; i < LANES; i++) par[i] = word[i*LANE_BITS + LANE_W];
    return par;
  endfunction

endpackage

// File: rtl/sram_parity_mem.sv
// 36-bit wide single-port-style storage: per-lane write enables on the write
// side and a registered (1-cycle) read port.
module sram_parity_mem
  import sram_parity_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [LANES-1:0]  wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_word
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // NOTE: storage has no reset on purpose; contents must survive rst and a
  // resettable array would not map onto an SRAM macro.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) mem[wr_addr][i*LANE_BITS +: LANE_BITS] <= wr_word[i*LANE_BITS +: LANE_BITS];
    end
    rd_word <= mem[rd_addr];
  end

endmodule

// File: rtl/sram_parity_ctrl.sv
// Byte-parity protected SRAM controller with checked read responses and a
// saturating error counter. Define SRAM_PARITY_ERR_INJECT_EN to add inj_mask.
module sram_parity_ctrl
  import sram_parity_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LANES-1:0]  req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [LANES-1:0]  rsp_err_bytes,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_sticky,
  input  logic              cnt_clr
`ifdef SRAM_PARITY_ERR_INJECT_EN
  ,
  input  logic [LANES-1:0]  inj_mask
`endif
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [LANES-1:0]  wr_en, wr_par, inj, rd_par;
  logic [WORD_W-1:0] wr_word, rd_word;
  logic [DATA_W-1:0] rd_data;
  logic              wr_fire, rd_fire, rsp_fire;

`ifdef SRAM_PARITY_ERR_INJECT_EN
  assign inj = inj_mask;
`else
  assign inj = '0;
`endif

  assign wr_fire  = (state == IDLE) && req_valid && req_we;
  assign rd_fire  = (state == IDLE) && req_valid && !req_we;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign wr_en    = wr_fire ? req_be : '0;
  assign wr_par   = byte_parity(req_wdata) ^ inj;
  assign wr_word  = pack_word(req_wdata, wr_par);
  assign rd_data  = word_data(rd_word);
  assign rd_par   = word_parity(rd_word);

  sram_parity_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (req_addr),
    .wr_word (wr_word),
    .rd_addr (rd_addr),
    .rd_word (rd_word)
  );

  // NOTE: state is updated with non-blocking assignments so every flop in the
  // design samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_we) state_nxt = RD;
      end
      RD:  state_nxt = CHK;
      CHK: state_nxt = RSP;
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath address latch; its value is irrelevant until the next read.
  always_ff @(posedge clk) begin
    if (rd_fire) rd_addr <= req_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata     <= '0;
      rsp_err_bytes <= '0;
      rsp_err       <= 1'b0;
    end else if (state == CHK) begin
      rsp_rdata     <= rd_data;
      rsp_err_bytes <= rd_par ^ byte_parity(rd_data);
      rsp_err       <= |(rd_par ^ byte_parity(rd_data));
    end
  end

  // Clear has priority over a coincident counting handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (cnt_clr) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (rsp_fire && rsp_err) begin
      if (err_count != '1) err_count <= err_count + CNT_W'(1);
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_parity_ctrl.sv
// Self-checking bench for sram_parity_ctrl: directed cases plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_sram_parity_ctrl;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 3;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [3:0]        rsp_err_bytes;
  logic [CNT_W-1:0]  err_count;
  logic              err_sticky;
  logic              cnt_clr;
  logic [3:0]        inj_mask;

  always #5 clk = ~clk;

  sram_parity_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .rsp_err_bytes (rsp_err_bytes),
    .err_count     (err_count),
    .err_sticky    (err_sticky),
`ifdef SRAM_PARITY_ERR_INJECT_EN
    .inj_mask      (inj_mask),
`endif
    .cnt_clr       (cnt_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] par_of(input logic [31:0] d);
    return {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
  endfunction

  // Reference model: memory image plus expected visible outputs.
  logic [31:0]       mem_d [DEPTH];
  logic [3:0]        mem_p [DEPTH];
  logic              exp_ready, exp_valid, exp_sticky;
  logic [31:0]       exp_rdata;
  logic [3:0]        exp_err_bytes;
  logic [CNT_W-1:0]  exp_count;
  logic [ADDR_W-1:0] pend_addr;
  int                lat;
  logic [3:0]        force_mask = 4'h0;
  logic              running = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_ready     <= 1'b1;
      exp_valid     <= 1'b0;
      exp_rdata     <= '0;
      exp_err_bytes <= '0;
      exp_count     <= '0;
      exp_sticky    <= 1'b0;
      lat           <= 0;
    end else begin
      if (exp_ready && req_valid) begin
        if (req_we) begin
          for (int i = 0; i < 4; i++) begin
            if (req_be[i]) begin
              mem_d[req_addr][i*8 +: 8] <= req_wdata[i*8 +: 8];
              mem_p[req_addr][i]        <= (^req_wdata[i*8 +: 8]) ^ inj_mask[i];
            end
          end
        end else begin
          exp_ready <= 1'b0;
          lat       <= 2;
          pend_addr <= req_addr;
        end
      end else if (lat != 0) begin
        lat <= lat - 1;
        if (lat == 1) begin
          exp_valid     <= 1'b1;
          exp_rdata     <= mem_d[pend_addr];
          exp_err_bytes <= mem_p[pend_addr] ^ par_of(mem_d[pend_addr]) ^ force_mask;
        end
      end else if (exp_valid && rsp_ready) begin
        exp_valid <= 1'b0;
        exp_ready <= 1'b1;
        if (exp_err_bytes != 4'h0) begin
          exp_sticky <= 1'b1;
          if (exp_count != {CNT_W{1'b1}}) exp_count <= exp_count + 1'b1;
        end
      end
      if (cnt_clr) begin
        exp_count  <= '0;
        exp_sticky <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (running && !rst) begin
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, exp_valid);
      check("err_count", err_count, exp_count);
      check("err_sticky", err_sticky, exp_sticky);
      if (exp_valid) begin
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err_bytes", rsp_err_bytes, exp_err_bytes);
        check("rsp_err", rsp_err, |exp_err_bytes);
      end
    end
  end

  logic        rand_clr = 1'b0;
  logic [31:0] got_rdata;
  logic [3:0]  got_bytes;
  logic        got_err;
  logic [35:0] forced_word;

  task automatic step();
    @(posedge clk);
    #1;
    cnt_clr = rand_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [3:0] inj);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    inj_mask  = inj;
    step();
    req_valid = 1'b0;
    req_we    = 1'b0;
    inj_mask  = 4'h0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int hold,
                         input logic [3:0] fmask, input logic clr_ack);
    int k;
    force_mask = fmask;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = a;
    step();
    req_valid = 1'b0;
    k = 1;
`ifndef SRAM_PARITY_ERR_INJECT_EN
    if (fmask != 4'h0) begin
      // Corrupt the stored parity as seen by the checker during its check cycle.
      step();
      k++;
      for (int i = 0; i < 4; i++)
        forced_word[i*9 +: 9] = {mem_p[a][i] ^ fmask[i], mem_d[a][i*8 +: 8]};
      force dut.rd_word = forced_word;
      step();
      k++;
      release dut.rd_word;
    end
`endif
    while (!rsp_valid && k < 20) begin
      step();
      k++;
    end
    check("rsp_latency", k, 3);
    got_rdata = rsp_rdata;
    got_bytes = rsp_err_bytes;
    got_err   = rsp_err;
    if (rsp_valid) begin
      repeat (hold) step();
      rsp_ready = 1'b1;
      cnt_clr   = clr_ack;
      step();
      rsp_ready = 1'b0;
      cnt_clr   = 1'b0;
    end
    force_mask = 4'h0;
  endtask

  task automatic err_read(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [3:0] mask, input logic clr_ack);
`ifdef SRAM_PARITY_ERR_INJECT_EN
    do_write(a, d, 4'hF, mask);
    do_read(a, 0, 4'h0, clr_ack);
`else
    do_write(a, d, 4'hF, 4'h0);
    do_read(a, 0, mask, clr_ack);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] last_addr;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    cnt_clr   = 1'b0;
    inj_mask  = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    running = 1'b1;
    #1;
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", rsp_err, 1'b0);
    check("reset_rsp_err_bytes", rsp_err_bytes, 4'h0);
    check("reset_err_count", err_count, 0);
    check("reset_err_sticky", err_sticky, 1'b0);
    step();

    for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), $urandom, 4'hF, 4'h0);

    do_write(3, 32'hFFFF_FFFF, 4'hF, 4'h0);
    do_read(3, 0, 4'h0, 1'b0);
    check("all_ones_rdata", got_rdata, 32'hFFFF_FFFF);
    check("all_ones_err", got_err, 1'b0);
    check("all_ones_err_bytes", got_bytes, 4'h0);

    do_write(5, 32'h1234_5678, 4'hF, 4'h0);
    do_write(5, 32'h0000_AB00, 4'b0010, 4'h0);
    do_read(5, 0, 4'h0, 1'b0);
    check("lane_merge_rdata", got_rdata, 32'h1234_AB78);
    check("lane_merge_err", got_err, 1'b0);

    do_write(5, 32'hDEAD_BEEF, 4'h0, 4'h0);
    do_read(5, 5, 4'h0, 1'b0);
    check("be_zero_rdata", got_rdata, 32'h1234_AB78);
    check("ready_after_release", req_ready, 1'b1);

    do_write(7, 32'hC0FF_EE07, 4'hF, 4'h0);
    req_valid = 1'b1;
    req_addr  = 7;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("post_reset_rsp_valid", rsp_valid, 1'b0);
      check("post_reset_req_ready", req_ready, 1'b1);
      step();
    end
    do_read(7, 0, 4'h0, 1'b0);
    check("kept_after_reset", got_rdata, 32'hC0FF_EE07);

    err_read(9, 32'hA5A5_A5A5, 4'b0100, 1'b0);
    check("inject_err_bytes", got_bytes, 4'b0100);
    check("inject_err", got_err, 1'b1);
    check("inject_rdata", got_rdata, 32'hA5A5_A5A5);
    check("first_err_count", err_count, 1);
    check("first_err_sticky", err_sticky, 1'b1);
    for (int i = 0; i < 7; i++) err_read(9, 32'hA5A5_A5A5, 4'b1001, 1'b0);
    check("saturated_count", err_count, 3'b111);
    err_read(9, 32'h0F0F_0F0F, 4'b0001, 1'b1);
    check("clear_wins_count", err_count, 0);
    check("clear_wins_sticky", err_sticky, 1'b0);

    rand_clr  = 1'b1;
    last_addr = '0;
    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [3:0]  m;
      logic [ADDR_W-1:0] a;
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 1) == 1) ? last_addr : ADDR_W'($urandom);
      m = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      if (r < 5) begin
`ifdef SRAM_PARITY_ERR_INJECT_EN
        do_write(a, $urandom, 4'($urandom), m);
`else
        do_write(a, $urandom, 4'($urandom), 4'h0);
`endif
        last_addr = a;
      end else if (r < 9) begin
`ifdef SRAM_PARITY_ERR_INJECT_EN
        do_read(a, $urandom_range(0, 3), 4'h0, 1'b0);
`else
        do_read(a, $urandom_range(0, 3), m, 1'b0);
`endif
      end else begin
        step();
      end
    end
    rand_clr = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
